// File: rtl/maze_wall_checker_if.sv
// Maze wall checker bus: direction requests, player position, maze row writes, result.
// Latency: n/a (signal bundle only).
// Backpressure: none; the checker ignores requests while busy.
interface maze_wall_checker_if;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic        maze_we;
    logic [4:0]  maze_wr_row;
    logic [31:0] maze_wr_data;
    logic        maze_wall;
    logic        wall_valid;
    logic        busy;

    // Requester side: drives directions, position and maze writes
    modport master (
        output up, down, left, right, player_x, player_y,
        output maze_we, maze_wr_row, maze_wr_data,
        input  maze_wall, wall_valid, busy
    );

    // Checker side
    modport slave (
        input  up, down, left, right, player_x, player_y,
        input  maze_we, maze_wr_row, maze_wr_data,
        output maze_wall, wall_valid, busy
    );
endinterface

// File: rtl/maze_wall_checker.sv
// Checks whether the cell the player is moving into is a wall (or off the 32x32 grid).
// Latency: direction sampled at E0, registered result plus wall_valid pulse after E2.
// Backpressure: none; new requests are ignored while busy, at most one check per 3 cycles.
module maze_wall_checker #(
    parameter int GRID_W = 32,
    parameter int GRID_H = 32
) (
    input  logic                clk,
    input  logic                reset,
    maze_wall_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOOKUP, RESULT} state_t;

    localparam logic [GRID_W-1:0] SIDE_ROW = {1'b1, {(GRID_W-2){1'b0}}, 1'b1};

    state_t            state;
    logic [GRID_W-1:0] maze [GRID_H];
    logic [GRID_W-1:0] rd_buf;
    logic [4:0]        tgt_x;
    logic [4:0]        tgt_y;
    logic              oob;
    logic              maze_wall_q;
    logic              wall_valid_q;

    logic [10:0]       nxt_x;
    logic [10:0]       nxt_y;
    logic              any_dir;
    logic              nxt_oob;

    // Candidate target cell: up beats down, left beats right, 11-bit wrap-around
    always_comb begin
        nxt_x = bus.player_x;
        nxt_y = bus.player_y;
        if (bus.up)
            nxt_y = bus.player_y - 11'd1;
        else if (bus.down)
            nxt_y = bus.player_y + 11'd1;
        if (bus.left)
            nxt_x = bus.player_x - 11'd1;
        else if (bus.right)
            nxt_x = bus.player_x + 11'd1;
        any_dir = bus.up | bus.down | bus.left | bus.right;
        nxt_oob = (nxt_x >= 11'(GRID_W)) | (nxt_y >= 11'(GRID_H));
    end

    // Maze storage: border pattern on reset, otherwise row writes at any time
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < GRID_H; r++)
                maze[r] <= (r == 0 || r == GRID_H - 1) ? '1 : SIDE_ROW;
        end else if (bus.maze_we) begin
            maze[bus.maze_wr_row] <= bus.maze_wr_data;
        end
    end

    // Lookup sequencer: latch target, read row (pre-write data on a same-edge write), emit result
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tgt_x        <= '0;
            tgt_y        <= '0;
            oob          <= 1'b0;
            rd_buf       <= '0;
            maze_wall_q  <= 1'b0;
            wall_valid_q <= 1'b0;
        end else begin
            wall_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_dir) begin
                        tgt_x <= nxt_x[4:0];
                        tgt_y <= nxt_y[4:0];
                        oob   <= nxt_oob;
                        state <= LOOKUP;
                    end else begin
                        maze_wall_q <= 1'b0;
                    end
                end
                LOOKUP: begin
                    rd_buf <= maze[tgt_y];
                    state  <= RESULT;
                end
                RESULT: begin
                    maze_wall_q  <= oob | rd_buf[tgt_x];
                    wall_valid_q <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.maze_wall  = maze_wall_q;
    assign bus.wall_valid = wall_valid_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_maze_wall_checker.sv
module tb_maze_wall_checker;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_q [$];

    maze_wall_checker_if bus ();

    maze_wall_checker #(.GRID_W(32), .GRID_H(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every wall_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!reset && bus.wall_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wall_valid: got pulse, expected none");
            end else begin
                check("maze_wall", {31'd0, bus.maze_wall}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic clear_dirs();
        bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0;
    endtask

    task automatic set_pos(input logic [10:0] px, input logic [10:0] py);
        bus.player_x = px;
        bus.player_y = py;
    endtask

    // Called at a negedge: one-cycle direction request, checks busy timing
    task automatic lookup(input string name, input logic [10:0] px, input logic [10:0] py,
                          input logic u, input logic d, input logic l, input logic r,
                          input bit exp);
        set_pos(px, py);
        bus.up = u; bus.down = d; bus.left = l; bus.right = r;
        exp_q.push_back(exp);
        @(negedge clk);
        clear_dirs();
        check({name, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check({name, "_busy_e1"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check({name, "_busy_e2"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wr_row(input logic [4:0] row, input logic [31:0] data);
        bus.maze_we = 1; bus.maze_wr_row = row; bus.maze_wr_data = data;
        @(negedge clk);
        bus.maze_we = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        clear_dirs();
        set_pos(11'd1, 11'd1);
        bus.maze_we = 0; bus.maze_wr_row = 0; bus.maze_wr_data = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_wall", {31'd0, bus.maze_wall}, 32'd0);
        check("rst_valid", {31'd0, bus.wall_valid}, 32'd0);
        @(negedge clk);

        // Border walls, open interior, out-of-bounds wraps
        lookup("up_top_border", 11'd1, 11'd1, 1, 0, 0, 0, 1'b1);
        lookup("right_open", 11'd1, 11'd1, 0, 0, 0, 1, 1'b0);
        lookup("left_wrap_oob", 11'd0, 11'd5, 0, 0, 1, 0, 1'b1);
        lookup("down_oob", 11'd31, 11'd31, 0, 1, 0, 0, 1'b1);
        lookup("right_border", 11'd30, 11'd5, 0, 0, 0, 1, 1'b1);
        lookup("open_30_30", 11'd29, 11'd30, 0, 0, 0, 1, 1'b0);
        check("idle_wall_cleared", {31'd0, bus.maze_wall}, 32'd0);

        // Row write then lookup sees new wall
        wr_row(5'd1, 32'h8000_0005);
        lookup("written_wall", 11'd1, 11'd1, 0, 0, 0, 1, 1'b1);
        wr_row(5'd1, 32'h8000_0001);
        lookup("restored_open", 11'd1, 11'd1, 0, 0, 0, 1, 1'b0);

        // Write landing on the LOOKUP edge: read returns pre-write data
        set_pos(11'd1, 11'd1);
        bus.right = 1;
        exp_q.push_back(1'b0);
        @(negedge clk);
        clear_dirs();
        bus.maze_we = 1; bus.maze_wr_row = 5'd1; bus.maze_wr_data = 32'h8000_0005;
        @(negedge clk);
        bus.maze_we = 0;
        repeat (2) @(negedge clk);
        lookup("write_took_effect", 11'd1, 11'd1, 0, 0, 0, 1, 1'b1);

        // Direction priority: bits 4 and 5 of row 4 are walls, (5,6) is open
        wr_row(5'd4, 32'h0000_0030);
        lookup("up_left_prio", 11'd5, 11'd5, 1, 0, 1, 0, 1'b1);
        lookup("up_down_prio", 11'd5, 11'd5, 1, 1, 0, 0, 1'b1);
        lookup("down_only", 11'd5, 11'd5, 0, 1, 0, 0, 1'b0);
        lookup("left_right_prio", 11'd6, 11'd4, 0, 0, 1, 1, 1'b1);

        // Held direction: pulse every 3 cycles, maze_wall steady once set
        set_pos(11'd5, 11'd5);
        bus.up = 1;
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("held_valid_%0d", i), {31'd0, bus.wall_valid},
                  {31'd0, (i % 3) == 2});
            if (i >= 2)
                check($sformatf("held_wall_%0d", i), {31'd0, bus.maze_wall}, 32'd1);
            if (i == 8) clear_dirs();
        end
        @(negedge clk);
        check("held_release_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("held_release_wall", {31'd0, bus.maze_wall}, 32'd0);

        // Reset during LOOKUP aborts, restores border, beats a concurrent write
        wr_row(5'd2, 32'hFFFF_FFFF);
        lookup("pre_abort_wall", 11'd1, 11'd1, 0, 1, 0, 0, 1'b1);
        lookup("prime_wall", 11'd1, 11'd1, 1, 0, 0, 0, 1'b1);
        set_pos(11'd1, 11'd2);
        bus.right = 1;
        @(negedge clk);
        clear_dirs();
        reset = 1;
        bus.maze_we = 1; bus.maze_wr_row = 5'd3; bus.maze_wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 0;
        bus.maze_we = 0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_wall", {31'd0, bus.maze_wall}, 32'd0);
        check("abort_valid", {31'd0, bus.wall_valid}, 32'd0);
        repeat (4) @(negedge clk);
        lookup("restored_row2", 11'd1, 11'd2, 0, 0, 0, 1, 1'b0);
        lookup("restored_row1", 11'd1, 11'd1, 0, 0, 0, 1, 1'b0);
        lookup("restored_row4", 11'd5, 11'd5, 1, 0, 1, 0, 1'b0);
        lookup("reset_beats_write", 11'd2, 11'd4, 1, 0, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/maze_wall_checker.md
MAZE_WALL_CHECKER -- requirements
Module: maze_wall_checker

Interface
REQ-001 Parameter GRID_W, 32, maze width in cells, fixed at 32 in this revision.
REQ-002 Parameter GRID_H, 32, maze height in cells, fixed at 32 in this revision.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 up / down / left / right  input  1 each  level direction requests, same signals the player block consumes.
REQ-006 player_x / player_y  input  11 each  current player cell coordinates.
REQ-007 maze_we  input  1  maze row write enable.
REQ-008 maze_wr_row  input  5  row index to write.
REQ-009 maze_wr_data  input  32  row contents; bit i = cell (x=i, row); 1 = wall.
REQ-010 maze_wall  output  1  registered result: the requested target cell is blocked.
REQ-011 wall_valid  output  1  one-cycle pulse when maze_wall carries a new result.
REQ-012 busy  output  1  high while a lookup is in flight (state not IDLE).

Function
REQ-013 Internal storage: 32 rows x 32 bits, registered.
REQ-014 States: IDLE, LOOKUP, RESULT; encoding free.
REQ-015 IDLE, any direction active at edge E0: latch target, go LOOKUP.
REQ-016 Target y: up -> player_y-1; else down -> player_y+1; else player_y (up priority).
REQ-017 Target x: left -> player_x-1; else right -> player_x+1; else player_x (left priority).
REQ-018 Target arithmetic 11-bit, modulo 2^11; 0-1 wraps to 2047.
REQ-019 Target out of bounds (x>=32 or y>=32, incl. wrapped values): latch oob flag.
REQ-020 LOOKUP (edge E1): register row[target_y[4:0]] into read buffer; go RESULT.
REQ-021 RESULT (edge E2): maze_wall <= oob | buffer[target_x[4:0]]; wall_valid <= 1; go IDLE.
REQ-022 Latency: sampling edge E0 -> maze_wall/wall_valid visible after E2; one check per 3 cycles max.
REQ-023 wall_valid high exactly one cycle per completed lookup; 0 all other cycles.
REQ-024 maze_wall holds last result while busy or while a direction stays held.
REQ-025 IDLE with no direction active: maze_wall <= 0 at that edge; wall_valid 0.
REQ-026 Directions changing during LOOKUP/RESULT ignored; latched target used.
REQ-027 maze_we applies at the edge in any state; write coexists with lookups.
REQ-028 Write and LOOKUP read of same row at same edge: read returns pre-write data.
REQ-029 Write issued after E1 does not affect the in-flight result.
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 Reset at any edge, any state: state IDLE, maze_wall 0, wall_valid 0, busy 0, latched target 0.
REQ-032 Reset loads maze border: rows 0 and 31 = 0xFFFF_FFFF; rows 1-30 = 0x8000_0001.
REQ-033 Reset mid-lookup aborts it; no wall_valid pulse for aborted lookup.
REQ-034 Reset has priority over maze_we in the same cycle.

Verification
REQ-035 Reset, player (1,1), up for 1 cycle -> target (1,0); 2 edges later maze_wall=1, wall_valid=1 for 1 cycle.
REQ-036 Reset, player (1,1), right -> target (2,1) open; maze_wall=0, wall_valid pulse; busy high exactly 2 cycles.
REQ-037 Player (0,5), left -> x wraps to 2047 -> maze_wall=1 (oob); player (31,31), down -> y=32 -> maze_wall=1.
REQ-038 Write row 1 = 0x8000_0005, then player (1,1), right -> cell (2,1) blocked, maze_wall=1; same write at E1 of an in-flight (2,1) lookup -> maze_wall=0.
REQ-039 Player (5,5), up+left held -> target (4,4); up+down -> target y=4; held direction -> result every 3 cycles, maze_wall steady between pulses.
REQ-040 Assert reset during LOOKUP -> next cycle busy=0, maze_wall=0, no wall_valid; maze restored to border pattern.
